// File: rtl/oric_tape_pkg.sv
// Shared types and constants for the Oric fast-format tape modulator.
package oric_tape_pkg;

    // Modulator states: waiting for work, holding a silent gap, or in one of the
    // two halves of a bit cell.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GAP    = 2'd1,
        BIT_HI = 2'd2,
        BIT_LO = 2'd3
    } tape_state_t;

    // A frame is start bit, eight data bits, odd parity and the stop bits.
    localparam int   FRAME_BITS = 14;
    localparam int   STOP_BITS  = 4;
    localparam logic IDLE_LEVEL = 1'b1;

    // Larger of two integers, used when sizing the shared down-counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Builds the frame so that bit 0 is transmitted first: start bit 0, data
    // LSB first, parity chosen so data plus parity has an odd number of ones,
    // then the stop bits at 1.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data);
        return {{STOP_BITS{1'b1}}, ~^data, data, 1'b0};
    endfunction

endpackage

// File: rtl/tape_bit_modulator_if.sv
// Handshake between the TAP sequencer and the tape modulator, plus the tape level.
interface tape_bit_modulator_if;

    logic       start;
    logic       gap;
    logic [7:0] din;
    logic       done;
    logic       busy;
    logic       dout;

    // The sequencer issues requests and watches completion.
    modport master (
        output start,
        output gap,
        output din,
        input  done,
        input  busy,
        input  dout
    );

    // The modulator takes requests and produces the waveform.
    modport slave (
        input  start,
        input  gap,
        input  din,
        output done,
        output busy,
        output dout
    );

endinterface

// File: rtl/tape_bit_modulator.sv
// Turns one byte (or one gap request) into the Oric fast-format cassette waveform.
// Every bit is a high half-unit followed by a low phase of one half-unit for a 1
// or two half-units for a 0. A single down-counter times both bit phases and gaps.
module tape_bit_modulator
    import oric_tape_pkg::*;
#(
    parameter int UNIT_CYCLES = 4992,
    parameter int GAP_CYCLES  = 2_400_000
) (
    input  logic                 clk,
    input  logic                 reset,
    tape_bit_modulator_if.slave  bus
);

    localparam int CNT_W = $clog2(max_int(2 * UNIT_CYCLES, GAP_CYCLES) + 1);

    localparam logic [CNT_W-1:0] HALF_LEN = CNT_W'(UNIT_CYCLES);
    localparam logic [CNT_W-1:0] FULL_LEN = CNT_W'(2 * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LEN  = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [3:0]       LAST_IDX = 4'(FRAME_BITS - 1);

    tape_state_t             state;
    tape_state_t             state_next;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_next;
    logic [FRAME_BITS-1:0]   frame;
    logic [FRAME_BITS-1:0]   frame_next;
    logic [3:0]              bit_idx;
    logic [3:0]              bit_idx_next;
    logic                    dout_q;
    logic                    dout_next;
    logic                    done_q;
    logic                    done_next;
    logic                    busy_q;
    logic                    busy_next;
    logic                    phase_end;

    // The counter is loaded with the full phase length, so a phase ends on the
    // edge where it still reads 1; that edge is also the first of the next phase.
    assign phase_end = (cnt <= CNT_ONE);

    assign bus.dout = dout_q;
    assign bus.done = done_q;
    assign bus.busy = busy_q;

    // Register every piece of state so all outputs come straight from flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            frame   <= '0;
            bit_idx <= '0;
            dout_q  <= IDLE_LEVEL;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            frame   <= frame_next;
            bit_idx <= bit_idx_next;
            dout_q  <= dout_next;
            done_q  <= done_next;
            busy_q  <= busy_next;
        end
    end

    // Next-state, counter, shift register and output decisions for the next edge.
    always_comb begin
        state_next   = state;
        cnt_next     = (cnt != '0) ? (cnt - CNT_ONE) : cnt;
        frame_next   = frame;
        bit_idx_next = bit_idx;
        dout_next    = dout_q;
        done_next    = 1'b0;
        busy_next    = busy_q;

        case (state)
            IDLE: begin
                dout_next = IDLE_LEVEL;
                busy_next = 1'b0;
                if (bus.start) begin
                    busy_next = 1'b1;
                    if (bus.gap) begin
                        state_next = GAP;
                        cnt_next   = GAP_LEN;
                    end else begin
                        state_next   = BIT_HI;
                        cnt_next     = HALF_LEN;
                        frame_next   = build_frame(bus.din);
                        bit_idx_next = '0;
                    end
                end
            end

            GAP: begin
                dout_next = IDLE_LEVEL;
                if (phase_end) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                end
            end

            BIT_HI: begin
                if (phase_end) begin
                    state_next = BIT_LO;
                    dout_next  = 1'b0;
                    cnt_next   = frame[0] ? HALF_LEN : FULL_LEN;
                end
            end

            BIT_LO: begin
                if (phase_end) begin
                    dout_next = IDLE_LEVEL;
                    if (bit_idx >= LAST_IDX) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                        done_next  = 1'b1;
                        busy_next  = 1'b0;
                    end else begin
                        state_next   = BIT_HI;
                        cnt_next     = HALF_LEN;
                        frame_next   = {IDLE_LEVEL, frame[FRAME_BITS-1:1]};
                        bit_idx_next = bit_idx + 4'd1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
                dout_next  = IDLE_LEVEL;
                busy_next  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_tape_bit_modulator.sv
// Directed bench for tape_bit_modulator with short unit and gap lengths.
module tb_tape_bit_modulator;

    localparam int U = 4;
    localparam int G = 20;

    logic clk = 1'b0;
    logic reset;

    int checks   = 0;
    int failures = 0;

    tape_bit_modulator_if bus ();

    tape_bit_modulator #(
        .UNIT_CYCLES (U),
        .GAP_CYCLES  (G)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock; inputs change and outputs are sampled on the falling edge.
    always #5 clk = ~clk;

    // Compares one observed value against its expected value and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, observed, observed, expected, expected);
        end
    endtask

    // Drives the request inputs of the sequencer side.
    task automatic applyStimulus(input logic s, input logic g, input logic [7:0] d);
        bus.start = s;
        bus.gap   = g;
        bus.din   = d;
    endtask

    // Sends one byte, measures the frame length, and decodes the waveform into bits.
    task automatic sendFrame(input string name, input logic [7:0] data, input int exp_len, input logic [13:0] exp_bits);
        logic        samp[$];
        int          j;
        bit          seen;
        int          busy_bad;
        int          idx;
        int          h;
        int          l;
        int          bad_hi;
        int          bad_lo;
        logic [13:0] got;

        applyStimulus(1'b1, 1'b0, data);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, ~data);
        checkOutput({name, "_done_low_after_accept"}, 32'(bus.done), 32'd0);

        j        = 0;
        seen     = 1'b0;
        busy_bad = 0;
        while (!seen && j < 400) begin
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                if (!bus.busy) busy_bad++;
                samp.push_back(bus.dout);
                @(negedge clk);
                j++;
            end
        end
        if (!seen) begin
            checkOutput({name, "_done_timeout"}, 32'd0, 32'd1);
            return;
        end

        checkOutput({name, "_frame_len"}, 32'(j), 32'(exp_len));
        checkOutput({name, "_busy_gaps"}, 32'(busy_bad), 32'd0);
        checkOutput({name, "_dout_at_done"}, 32'(bus.dout), 32'd1);
        checkOutput({name, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        @(negedge clk);
        checkOutput({name, "_done_one_cycle"}, 32'(bus.done), 32'd0);

        idx    = 0;
        bad_hi = 0;
        bad_lo = 0;
        got    = '0;
        for (int b = 0; b < 14; b++) begin
            h = 0;
            while (idx < samp.size() && samp[idx] == 1'b1) begin
                h++;
                idx++;
            end
            l = 0;
            while (idx < samp.size() && samp[idx] == 1'b0) begin
                l++;
                idx++;
            end
            if (h != U) bad_hi++;
            if (l == U)           got[b] = 1'b1;
            else if (l == 2 * U)  got[b] = 1'b0;
            else                  bad_lo++;
        end
        checkOutput({name, "_decoded_bits"}, 32'(got), 32'(exp_bits));
        checkOutput({name, "_bad_high_phases"}, 32'(bad_hi), 32'd0);
        checkOutput({name, "_bad_low_phases"}, 32'(bad_lo), 32'd0);
        checkOutput({name, "_trailing_samples"}, 32'(samp.size() - idx), 32'd0);
    endtask

    initial begin
        int low_cnt;
        int done_cnt;
        int done_at;
        int busy_bad;

        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 10; i++) begin
            checkOutput("idle_dout", 32'(bus.dout), 32'd1);
            checkOutput("idle_done", 32'(bus.done), 32'd0);
            checkOutput("idle_busy", 32'(bus.busy), 32'd0);
            @(negedge clk);
        end

        // Bits are listed with the first transmitted bit in position 0.
        sendFrame("byte_00", 8'h00, 148, 14'h3E00);
        sendFrame("byte_FF", 8'hFF, 116, 14'h3FFE);
        sendFrame("byte_16", 8'h16, 140, 14'h3C2C);

        // Gap with an ignored re-pulse at cycle 5 and start held into the done edge.
        applyStimulus(1'b1, 1'b1, 8'h33);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 8'h33);
        low_cnt  = 0;
        done_cnt = 0;
        done_at  = -1;
        busy_bad = 0;
        for (int j = 0; j <= 30; j++) begin
            if (!bus.dout) low_cnt++;
            if (bus.done) begin
                done_cnt++;
                done_at = j;
            end
            if (j < G && !bus.busy) busy_bad++;
            if (j == G + 1) checkOutput("gap_busy_after_done", 32'(bus.busy), 32'd0);
            if (j == 4)           applyStimulus(1'b1, 1'b0, 8'hC3);
            else if (j == 5)      applyStimulus(1'b0, 1'b0, 8'h3C);
            else if (j == G - 1)  applyStimulus(1'b1, 1'b1, 8'h00);
            else if (j == G)      applyStimulus(1'b0, 1'b0, 8'h00);
            @(negedge clk);
        end
        checkOutput("gap_dout_low_cycles", 32'(low_cnt), 32'd0);
        checkOutput("gap_done_count", 32'(done_cnt), 32'd1);
        checkOutput("gap_done_cycle", 32'(done_at), 32'(G));
        checkOutput("gap_busy_gaps", 32'(busy_bad), 32'd0);

        // Reset in the middle of a frame aborts it without a done pulse.
        applyStimulus(1'b1, 1'b0, 8'h00);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 8'h00);
        for (int j = 0; j < 30; j++) begin
            if (j == 29) begin
                checkOutput("abort_dout_before_reset", 32'(bus.dout), 32'd0);
                reset = 1'b1;
            end
            @(negedge clk);
        end
        reset = 1'b0;
        checkOutput("abort_dout", 32'(bus.dout), 32'd1);
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        checkOutput("abort_done", 32'(bus.done), 32'd0);
        done_cnt = 0;
        for (int j = 0; j < 200; j++) begin
            if (bus.done) done_cnt++;
            @(negedge clk);
        end
        checkOutput("abort_no_done", 32'(done_cnt), 32'd0);
        sendFrame("after_abort_00", 8'h00, 148, 14'h3E00);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/tape_bit_modulator.md
# tape_bit_modulator

Byte-to-waveform modulator for the Oric tape path. It accepts one byte, or one gap request, per handshake from the cassette TAP sequencer. It emits the corresponding Oric fast-format cassette waveform on a single-bit output that feeds the ULA/VIA tape input. It is the stage directly downstream of the sequencer's `start`/`gap`/`din`/`done` interface.

## Interface
- `UNIT_CYCLES`, default 4992: clk cycles per half-unit (208 µs at 24 MHz); must be ≥ 2.
- `GAP_CYCLES`, default 2_400_000: length of a gap, in clk cycles (100 ms at 24 MHz); must be ≥ 1.
- `clk`  in  1  clock; all logic is rising-edge.
- `reset`  in  1  reset, synchronous, active-high.
- `start`  in  1  request; sampled only in IDLE; may be held high for more than one cycle.
- `gap`  in  1  sampled with `start`; 1 = emit gap, 0 = emit byte frame.
- `din`  in  8  byte to send; latched on the accepting edge.
- `done`  out  1  single-cycle pulse when a frame or gap completes; low at all other times.
- `busy`  out  1  high from the accepting edge until the `done` edge.
- `dout`  out  1  registered tape level; idle level 1.

## Operation
- Reset values: `dout`=1, `done`=0, `busy`=0, state IDLE, all counters 0.
- States: IDLE, GAP, BIT_HI, BIT_LO.
- IDLE with `start`=1 and `gap`=1: go to GAP. Load the counter with GAP_CYCLES. `dout` stays 1.
- IDLE with `start`=1 and `gap`=0: latch the frame and go to BIT_HI.
- Frame is 14 bits, sent in this order:
  - start bit 0;
  - `din[0]`..`din[7]`, LSB first;
  - parity = ~^din, so the total count of ones in data plus parity is odd;
  - 4 stop bits of 1.
- Each bit is one high phase followed by one low phase:
  - high phase: `dout`=1 for UNIT_CYCLES;
  - low phase for bit 1: `dout`=0 for UNIT_CYCLES;
  - low phase for bit 0: `dout`=0 for 2×UNIT_CYCLES.
- Bit sequencing: BIT_HI goes to BIT_LO, then back to BIT_HI for the next bit. After the low phase of bit 13, return to IDLE.
- GAP counts down to zero, then returns to IDLE.
- `start` while busy is ignored. This includes the edge on which `done` pulses, because the block is not yet in IDLE at that edge.
- `gap` and `din` changes after the accepting edge have no effect.
- Reset mid-frame or mid-gap aborts immediately. No `done` is produced for the aborted request.

## Timing
- Let the accepting edge be k.
  - `busy`=1 from edge k.
  - `dout` follows the phase schedule starting at edge k; the first high phase occupies cycles k..k+U−1.
- Frame length N = U × (2×ones + 3×zeros) over the 14 bits, where U = UNIT_CYCLES.
- At edge k+N:
  - `done`=1 for exactly one cycle;
  - `busy`=0;
  - `dout`=1;
  - state is IDLE.
- Gap: `done` is asserted at edge k+GAP_CYCLES. `dout`=1 throughout the gap.
- Earliest next acceptance is edge k+N+1.
- Phase counter width is $clog2(max(2×UNIT_CYCLES, GAP_CYCLES)+1).
- Bit index is 4 bits wide and saturates at 13. There is no wrap into a second frame.
- `done` is guaranteed low on the edge after `start` is accepted. The sequencer therefore never samples a stale `done`.

## Structure
- Package `oric_tape_pkg`:
  - state enum;
  - constants FRAME_BITS=14, STOP_BITS=4, IDLE_LEVEL=1'b1.
- A single module; no sub-module is natural.
  - One down-counter is shared by the phase timing and the gap timing.
  - One 14-bit shift register holds the frame.

## Test plan
Bench uses UNIT_CYCLES=4 and GAP_CYCLES=20.
- Reset, then idle 10 cycles -> `dout`=1, `done`=0, `busy`=0 throughout.
- Send `din`=8'h00 -> parity 1; `done` exactly 148 cycles after acceptance; 9 low phases of 8 cycles, then 5 low phases of 4 cycles.
- Send `din`=8'hFF -> parity 1; `done` after 116 cycles; only the first low phase is 8 cycles.
- Send `din`=8'h16 -> decoded bits 0,0,1,1,0,1,0,0,0,0,1,1,1,1 (start, data LSB-first, parity, stop); `done` after 140 cycles.
- Send `start` with `gap`=1, re-pulse `start` at cycle 5, and change `din` -> `dout` stays 1; single `done` at cycle 20; the re-pulse is ignored.
- Assert `reset` for one cycle at cycle 30 of an 8'h00 frame -> next cycle `dout`=1 and `busy`=0; no `done`; a new frame then completes normally.
